uart_rx: RTL and testbench

//  8N1 UART receiver; the receive-side counterpart of the SoC's uart_tx_o path.

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx : 8N1 UART receiver with a one-entry valid/ready holding register  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, rx_s_q, rx_s_d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             complete;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_s_d_q  <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= uart_rx_i;
      rx_s_q    <= sync1_q;
      rx_s_d_q  <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    complete  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Edge-triggered so a held-low (break) line cannot restart a frame.
        if (!rx_s_q && rx_s_d_q) state_d = START;
      end
      START: begin
        bit_idx_d = 3'd0;
        if (cnt_q == CNT_HALF) state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          complete = rx_s_q;
          ferr_d   = !rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // A byte completing into a full register may replace it only if the
    // consumer is taking the old one in the same cycle.
    if (complete) begin
      if (!valid_q || rx_ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx : randomized self-checking bench for uart_rx (16 clocks per bit).
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, frame_err_o, overrun_o, busy_o;

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .uart_rx_i   (rx_line),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (ready),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed-event log, sampled on the falling edge; tasks only read it.
  logic [7:0] got_q[$];
  int valid_cyc = 0, ferr_cyc = 0, ovr_cyc = 0, busy_cyc = 0;
  always @(negedge clk) begin
    if (rx_valid_o && ready) got_q.push_back(rx_data_o);
    if (rx_valid_o)  valid_cyc++;
    if (frame_err_o) ferr_cyc++;
    if (overrun_o)   ovr_cyc++;
    if (busy_o)      busy_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rx_line = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_line = 1'b1; ready = 1'b0;
    repeat (4) tick();
    n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid_o); end
    n_checks++; if (rx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data_o); end
    n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_single();
    int g0, v0, f0, o0;
    logic [7:0] b;
    g0 = got_q.size(); v0 = valid_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
    ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    repeat (20) tick();
    b = (got_q.size() > g0) ? got_q[g0] : 8'hxx;
    n_checks++; if (valid_cyc - v0 != 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d want 1", valid_cyc - v0); end
    n_checks++; if (got_q.size() - g0 != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", got_q.size() - g0); end
    n_checks++; if (b !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", b); end
    n_checks++; if (ferr_cyc != f0 || ovr_cyc != o0) begin n_fail++; $display("FAIL single_flags: got ferr %0d ovr %0d want 0 0", ferr_cyc - f0, ovr_cyc - o0); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_overrun();
    int g0, o0, f0;
    logic [7:0] b;
    g0 = got_q.size(); o0 = ovr_cyc; f0 = ferr_cyc;
    ready = 1'b0;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) tick();
    n_checks++; if (ovr_cyc - o0 != 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d cycles want 1", ovr_cyc - o0); end
    n_checks++; if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b want 1", rx_valid_o); end
    n_checks++; if (rx_data_o !== 8'h00) begin n_fail++; $display("FAIL ovr_data_kept: got %h want 00", rx_data_o); end
    n_checks++; if (ferr_cyc != f0) begin n_fail++; $display("FAIL ovr_ferr: got %0d want 0", ferr_cyc - f0); end
    ready = 1'b1;
    tick();
    n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop: got %b want 0", rx_valid_o); end
    repeat (10) tick();
    b = (got_q.size() > g0) ? got_q[g0] : 8'hxx;
    n_checks++; if (got_q.size() - g0 != 1 || b !== 8'h00) begin n_fail++; $display("FAIL ovr_accepted: got %0d bytes first %h want 1 byte 00", got_q.size() - g0, b); end
  endtask

  task automatic test_glitch();
    int v0, b0, f0, o0;
    v0 = valid_cyc; b0 = busy_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
    ready = 1'b1;
    rx_line = 1'b0;
    repeat (5) tick();
    rx_line = 1'b1;
    repeat (30) tick();
    n_checks++; if (busy_cyc == b0) begin n_fail++; $display("FAIL glitch_busy_pulse: got 0 busy cycles want >0"); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got busy %b want 0", busy_o); end
    n_checks++; if (valid_cyc != v0 || ferr_cyc != f0 || ovr_cyc != o0) begin n_fail++; $display("FAIL glitch_quiet: got valid %0d ferr %0d ovr %0d want 0 0 0", valid_cyc - v0, ferr_cyc - f0, ovr_cyc - o0); end
  endtask

  task automatic test_framing();
    int g0, f0, v0;
    logic [7:0] b;
    g0 = got_q.size(); f0 = ferr_cyc; v0 = valid_cyc;
    ready = 1'b1;
    send_frame(8'h55, 1'b0);
    repeat (2 * CPB) tick();
    send_frame(8'h3C, 1'b1);
    repeat (20) tick();
    b = (got_q.size() > g0) ? got_q[g0] : 8'hxx;
    n_checks++; if (ferr_cyc - f0 != 1) begin n_fail++; $display("FAIL frame_err_pulse: got %0d want 1", ferr_cyc - f0); end
    n_checks++; if (got_q.size() - g0 != 1 || b !== 8'h3C) begin n_fail++; $display("FAIL frame_next_byte: got %0d bytes first %h want 1 byte 3c", got_q.size() - g0, b); end
    n_checks++; if (valid_cyc - v0 != 1) begin n_fail++; $display("FAIL frame_valid_cycles: got %0d want 1", valid_cyc - v0); end
  endtask

  task automatic test_reset_mid();
    int g0;
    logic [7:0] d, b;
    d = 8'h81;
    ready = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_line = d[4];
    repeat (CPB / 2) tick();
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy_o); end
    g0 = got_q.size();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx_line = 1'b1;
    n_checks++; if ({rx_valid_o, frame_err_o, overrun_o, busy_o} !== 4'b0000 || rx_data_o !== 8'h00) begin
      n_fail++; $display("FAIL midrst_outputs: got v%b f%b o%b b%b d%h want all 0", rx_valid_o, frame_err_o, overrun_o, busy_o, rx_data_o);
    end
    repeat (3 * CPB) tick();
    send_frame(8'h7E, 1'b1);
    repeat (20) tick();
    b = (got_q.size() > g0) ? got_q[g0] : 8'hxx;
    n_checks++; if (got_q.size() - g0 != 1 || b !== 8'h7E) begin n_fail++; $display("FAIL midrst_next_byte: got %0d bytes first %h want 1 byte 7e", got_q.size() - g0, b); end
  endtask

  task automatic test_back_to_back();
    int g0, o0, v0;
    logic [7:0] d, b0, b1;
    g0 = got_q.size(); o0 = ovr_cyc;
    ready = 1'b0;
    send_frame(8'h34, 1'b1);
    repeat (10) tick();
    n_checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h34) begin n_fail++; $display("FAIL b2b_first_held: got v%b d%h want v1 d34", rx_valid_o, rx_data_o); end
    v0 = valid_cyc;
    d = 8'h12;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    // Stop sample lands 10 cycles into the stop bit (2 sync + half bit).
    rx_line = 1'b1;
    repeat (10) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    repeat (5) tick();
    n_checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h12) begin n_fail++; $display("FAIL b2b_second_loaded: got v%b d%h want v1 d12", rx_valid_o, rx_data_o); end
    n_checks++; if (ovr_cyc != o0) begin n_fail++; $display("FAIL b2b_no_overrun: got %0d want 0", ovr_cyc - o0); end
    n_checks++; if (valid_cyc - v0 != 9 * CPB + 16) begin n_fail++; $display("FAIL b2b_valid_continuous: got %0d want %0d", valid_cyc - v0, 9 * CPB + 16); end
    ready = 1'b1;
    repeat (5) tick();
    b0 = (got_q.size() > g0)     ? got_q[g0]     : 8'hxx;
    b1 = (got_q.size() > g0 + 1) ? got_q[g0 + 1] : 8'hxx;
    n_checks++; if (got_q.size() - g0 != 2 || b0 !== 8'h34 || b1 !== 8'h12) begin n_fail++; $display("FAIL b2b_sequence: got %0d bytes %h %h want 34 12", got_q.size() - g0, b0, b1); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d, b;
    logic       stop;
    int g0, f0, o0, bad;
    g0 = got_q.size(); f0 = ferr_cyc; o0 = ovr_cyc; bad = 0;
    ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(3, 0) != 0);
      send_frame(d, stop);
      if (stop) exp_q.push_back(d);
      else      bad++;
      repeat (stop ? $urandom_range(10, 0) : $urandom_range(40, 2 * CPB)) tick();
    end
    repeat (30) tick();
    n_checks++; if (got_q.size() - g0 != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - g0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      b = (got_q.size() > g0 + i) ? got_q[g0 + i] : 8'hxx;
      n_checks++; if (b !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte[%0d]: got %h want %h", i, b, exp_q[i]); end
    end
    n_checks++; if (ferr_cyc - f0 != bad) begin n_fail++; $display("FAIL rand_ferr: got %0d want %0d", ferr_cyc - f0, bad); end
    n_checks++; if (ovr_cyc != o0) begin n_fail++; $display("FAIL rand_ovr: got %0d want 0", ovr_cyc - o0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
